// File: rtl/varint_field_sched_if.sv
// Requester, varint-unit and response signals of varint_field_sched.
// The slave modport is the scheduler's view; master is the surrounding requesters and varint unit.
interface varint_field_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][28:0] req_field_num;
  logic [NUM_REQ-1:0][4:0]  req_field_type;
  logic [NUM_REQ-1:0][63:0] req_value;

  logic        vu_en;
  logic [63:0] vu_dst_addr;
  logic [63:0] vu_value;
  logic [4:0]  vu_field_type;
  logic        vu_done;
  logic [3:0]  vu_bytes_written;

  logic        resp_valid;
  logic [2:0]  resp_id;
  logic [4:0]  resp_bytes;
  logic        resp_err;

  modport slave (
    input  req_valid, req_field_num, req_field_type, req_value, vu_done, vu_bytes_written,
    output req_ready, vu_en, vu_dst_addr, vu_value, vu_field_type,
    output resp_valid, resp_id, resp_bytes, resp_err
  );

  modport master (
    output req_valid, req_field_num, req_field_type, req_value, vu_done, vu_bytes_written,
    input  req_ready, vu_en, vu_dst_addr, vu_value, vu_field_type,
    input  resp_valid, resp_id, resp_bytes, resp_err
  );
endinterface

// File: rtl/varint_field_sched.sv
// Round-robin scheduler sharing one varint unit: per field emits tag then value at wr_ptr.
// Optional watchdog per varint op: define VARINT_SCHED_TIMEOUT_EN.
module varint_field_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_load,
  input  logic [63:0]          cfg_base_addr,
  varint_field_sched_if.slave  bus,
  output logic [63:0]          wr_ptr,
  output logic [31:0]          total_bytes,
  output logic                 busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("varint_field_sched: NUM_REQ must be 2..8 and TIMEOUT_CYC nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_TAG, S_GAP1, S_VAL, S_DONE, S_ERR, S_ABORT
  } state_t;

  state_t state, state_nx;

  logic [2:0]         rr_ptr, id, gnt_idx, cand;
  logic               gnt_found;
  logic [7:0]         valid8;
  logic [NUM_REQ-1:0] gnt_onehot, ready_q;
  logic [28:0]        gnt_fnum;
  logic [4:0]         gnt_type, ftype, fbytes;
  logic [63:0]        gnt_val, fval;
  logic [63:0]        dst_q, value_q;
  logic [4:0]         vtype_q;
  logic               timeout;

  function automatic logic is_varint(input logic [4:0] t);
    case (t)
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: is_varint = 1'b1;
      default:                                          is_varint = 1'b0;
    endcase
  endfunction

  // Rotating-priority search starting at rr_ptr, then mux out the winner's descriptor.
  always_comb begin
    valid8     = 8'(bus.req_valid);
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    gnt_onehot = '0;
    gnt_fnum   = '0;
    gnt_type   = '0;
    gnt_val    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 3'((32'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_found && valid8[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (gnt_found && 3'(j) == gnt_idx) begin
        gnt_onehot[j] = 1'b1;
        gnt_fnum      = bus.req_field_num[j];
        gnt_type      = bus.req_field_type[j];
        gnt_val       = bus.req_value[j];
      end
    end
  end

`ifdef VARINT_SCHED_TIMEOUT_EN
  logic [31:0] wdog;

  // Every TAG/VAL stint is entered from a different state, so clearing outside them restarts the count.
  always_ff @(posedge clk) begin
    if (reset || !(state == S_TAG || state == S_VAL)) wdog <= '0;
    else                                              wdog <= wdog + 32'd1;
  end

  assign timeout = (wdog == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!cfg_load && gnt_found) state_nx = is_varint(gnt_type) ? S_TAG : S_ERR;
      S_TAG:   if (bus.vu_done) state_nx = S_GAP1;
               else if (timeout) state_nx = S_ABORT;
      S_GAP1:  state_nx = S_VAL;
      S_VAL:   if (bus.vu_done) state_nx = S_DONE;
               else if (timeout) state_nx = S_ABORT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      id          <= '0;
      ftype       <= '0;
      fval        <= '0;
      fbytes      <= '0;
      ready_q     <= '0;
      dst_q       <= '0;
      value_q     <= '0;
      vtype_q     <= '0;
      wr_ptr      <= '0;
      total_bytes <= '0;
    end else begin
      ready_q <= '0;
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            wr_ptr      <= cfg_base_addr;
            total_bytes <= '0;
          end else if (gnt_found) begin
            ready_q <= gnt_onehot;
            id      <= gnt_idx;
            ftype   <= gnt_type;
            fval    <= gnt_val;
            fbytes  <= '0;
            rr_ptr  <= 3'((32'(gnt_idx) + 1) % NUM_REQ);
            dst_q   <= wr_ptr;
            value_q <= {32'b0, gnt_fnum, 3'b000};
            vtype_q <= 5'd4;
          end
        end
        S_TAG: if (bus.vu_done) begin
          wr_ptr      <= wr_ptr + 64'(bus.vu_bytes_written);
          total_bytes <= total_bytes + 32'(bus.vu_bytes_written);
          fbytes      <= 5'(bus.vu_bytes_written);
        end
        S_GAP1: begin
          dst_q   <= wr_ptr;
          value_q <= fval;
          vtype_q <= ftype;
        end
        S_VAL: if (bus.vu_done) begin
          wr_ptr      <= wr_ptr + 64'(bus.vu_bytes_written);
          total_bytes <= total_bytes + 32'(bus.vu_bytes_written);
          fbytes      <= fbytes + 5'(bus.vu_bytes_written);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.vu_en         = (state == S_TAG) || (state == S_VAL);
  assign bus.vu_dst_addr   = dst_q;
  assign bus.vu_value      = value_q;
  assign bus.vu_field_type = vtype_q;
  assign bus.resp_valid    = (state == S_DONE) || (state == S_ERR) || (state == S_ABORT);
  assign bus.resp_err      = (state == S_ERR) || (state == S_ABORT);
  assign bus.resp_id       = bus.resp_valid ? id : 3'd0;
  assign bus.resp_bytes    = bus.resp_valid ? fbytes : 5'd0;
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_varint_field_sched.sv
// Directed bench for varint_field_sched; the bench plays requesters and the varint unit.
// The watchdog section runs only when VARINT_SCHED_TIMEOUT_EN is defined.
module tb_varint_field_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [63:0] cfg_base_addr;
  logic [63:0] wr_ptr;
  logic [31:0] total_bytes;
  logic        busy;

  varint_field_sched_if #(.NUM_REQ(NREQ)) bus ();

  varint_field_sched #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_load      (cfg_load),
    .cfg_base_addr (cfg_base_addr),
    .bus           (bus),
    .wr_ptr        (wr_ptr),
    .total_bytes   (total_bytes),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_ptr;
  logic [31:0] exp_total;

  // tb/vb: byte counts the stand-in varint unit reports for tag and value.
  typedef struct {
    logic        ld;
    logic [63:0] base;
    int unsigned r;
    logic [28:0] fnum;
    logic [4:0]  ftype;
    logic [63:0] val;
    logic [3:0]  tb;
    logic [3:0]  vb;
    logic        err;
    logic [63:0] tag;
    logic [4:0]  rbytes;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_done(input logic [3:0] n);
    bus.vu_done          = 1'b1;
    bus.vu_bytes_written = n;
    @(negedge clk);
    bus.vu_done          = 1'b0;
    bus.vu_bytes_written = '0;
  endtask

  task automatic wait_ready(input int unsigned r);
    for (int n = 0; n < 20 && !bus.req_ready[r]; n++) @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(1 << r));
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic post(input int unsigned r, input logic [28:0] fnum, input logic [4:0] t,
                      input logic [63:0] v);
    bus.req_field_num[r]  = fnum;
    bus.req_field_type[r] = t;
    bus.req_value[r]      = v;
    bus.req_valid[r]      = 1'b1;
  endtask

  task automatic run_field(input vec_t v);
    if (v.ld) begin
      cfg_base_addr = v.base;
      cfg_load      = 1'b1;
      @(negedge clk);
      cfg_load  = 1'b0;
      exp_ptr   = v.base;
      exp_total = '0;
    end
    post(v.r, v.fnum, v.ftype, v.val);
    wait_ready(v.r);
    if (v.err) begin
      chk("err_vu_en", 64'(bus.vu_en), 64'd0);
      chk("err_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("err_resp_err", 64'(bus.resp_err), 64'd1);
      chk("err_resp_id", 64'(bus.resp_id), 64'(v.r));
      chk("err_resp_bytes", 64'(bus.resp_bytes), 64'(v.rbytes));
      @(negedge clk);
      chk("err_resp_pulse", 64'(bus.resp_valid), 64'd0);
      chk("err_wr_ptr", wr_ptr, exp_ptr);
    end else begin
      chk("tag_en", 64'(bus.vu_en), 64'd1);
      chk("tag_addr", bus.vu_dst_addr, exp_ptr);
      chk("tag_value", bus.vu_value, v.tag);
      chk("tag_type", 64'(bus.vu_field_type), 64'd4);
      repeat (2) @(negedge clk);
      pulse_done(v.tb);
      exp_ptr   = exp_ptr + 64'(v.tb);
      exp_total = exp_total + 32'(v.tb);
      chk("gap_en", 64'(bus.vu_en), 64'd0);
      @(negedge clk);
      chk("val_en", 64'(bus.vu_en), 64'd1);
      chk("val_addr", bus.vu_dst_addr, exp_ptr);
      chk("val_value", bus.vu_value, v.val);
      chk("val_type", 64'(bus.vu_field_type), 64'(v.ftype));
      pulse_done(v.vb);
      exp_ptr   = exp_ptr + 64'(v.vb);
      exp_total = exp_total + 32'(v.vb);
      chk("resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("resp_id", 64'(bus.resp_id), 64'(v.r));
      chk("resp_bytes", 64'(bus.resp_bytes), 64'(v.rbytes));
      chk("resp_err", 64'(bus.resp_err), 64'd0);
      chk("done_vu_en", 64'(bus.vu_en), 64'd0);
      chk("wr_ptr", wr_ptr, exp_ptr);
      chk("total_bytes", 64'(total_bytes), 64'(exp_total));
      @(negedge clk);
      chk("resp_pulse", 64'(bus.resp_valid), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int   exp_seq[5];
    int   ng;
    logic prev, seen;

    //            ld    base                   r  fnum          t      value                   tb vb err tag           rb
    vecs[0]  = '{1'b1, 64'h1000,              0, 29'd1,        5'd4,  64'd150,                1, 2, 0, 64'h08,       5'd3};
    vecs[1]  = '{1'b0, 64'h0,                 1, 29'd2,        5'd17, 64'hFFFF_FFFF,          1, 1, 0, 64'h10,       5'd2};
    vecs[2]  = '{1'b0, 64'h0,                 2, 29'd3,        5'd9,  64'd5,                  0, 0, 1, 64'h0,        5'd0};
    vecs[3]  = '{1'b0, 64'h0,                 3, 29'h1FFF_FFFF, 5'd18, 64'h8000_0000_0000_0000, 5, 10, 0, 64'hFFFF_FFF8, 5'd15};
    vecs[4]  = '{1'b0, 64'h0,                 0, 29'd5,        5'd3,  64'd0,                  1, 1, 0, 64'h28,       5'd2};
    vecs[5]  = '{1'b0, 64'h0,                 1, 29'd6,        5'd0,  64'd7,                  0, 0, 1, 64'h0,        5'd0};
    vecs[6]  = '{1'b0, 64'h0,                 2, 29'd7,        5'd19, 64'd7,                  0, 0, 1, 64'h0,        5'd0};
    vecs[7]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3, 29'd16,     5'd13, 64'd300,                2, 2, 0, 64'h80,       5'd4};
    vecs[8]  = '{1'b0, 64'h0,                 0, 29'd4,        5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 1, 10, 0, 64'h20,      5'd11};
    vecs[9]  = '{1'b0, 64'h0,                 1, 29'd9,        5'd8,  64'd1,                  1, 1, 0, 64'h48,       5'd2};
    vecs[10] = '{1'b0, 64'h0,                 2, 29'd10,       5'd14, 64'd2,                  1, 1, 0, 64'h50,       5'd2};
    exp_seq = '{0, 1, 2, 3, 0};

    reset                = 1'b1;
    cfg_load             = 1'b0;
    cfg_base_addr        = '0;
    bus.req_valid        = '0;
    bus.req_field_num    = '0;
    bus.req_field_type   = '0;
    bus.req_value        = '0;
    bus.vu_done          = 1'b0;
    bus.vu_bytes_written = '0;
    exp_ptr              = '0;
    exp_total            = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_vu_en", 64'(bus.vu_en), 64'd0);
    chk("rst_vu_dst", bus.vu_dst_addr, 64'd0);
    chk("rst_vu_value", bus.vu_value, 64'd0);
    chk("rst_vu_type", 64'(bus.vu_field_type), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_wr_ptr", wr_ptr, 64'd0);
    chk("rst_total", 64'(total_bytes), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Reset while the value op is in flight: everything clears, no response follows.
    post(0, 29'd1, 5'd4, 64'd150);
    wait_ready(0);
    @(negedge clk);
    pulse_done(4'd1);
    @(negedge clk);
    chk("pre_rst_val_en", 64'(bus.vu_en), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_vu_en", 64'(bus.vu_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wr_ptr", wr_ptr, 64'd0);
    chk("midrst_resp", 64'(bus.resp_valid), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    chk("midrst_no_resp", 64'(seen), 64'd0);

    // All four requesters (rejected type) held valid: grant order 0,1,2,3,0.
    for (int i = 0; i < 4; i++) post(i, 29'(i + 1), 5'd9, 64'd0);
    ng   = 0;
    prev = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge clk);
      seen = seen | bus.vu_en;
      if (bus.req_ready != '0) begin
        chk("rr_grant", 64'(bus.req_ready), 64'(1 << exp_seq[ng]));
        chk("rr_single_pulse", 64'(prev), 64'd0);
        ng++;
      end
      prev = (bus.req_ready != '0);
    end
    bus.req_valid = '0;
    chk("rr_count", 64'(ng), 64'd5);
    chk("rr_vu_en_low", 64'(seen), 64'd0);
    @(negedge clk);
    @(negedge clk);

    // cfg_load wins over a pending request in IDLE.
    post(0, 29'd1, 5'd4, 64'd150);
    cfg_base_addr = 64'h1000;
    cfg_load      = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("load_no_grant", 64'(bus.req_ready), 64'd0);
    chk("load_wr_ptr", wr_ptr, 64'h1000);
    chk("load_total", 64'(total_bytes), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    exp_ptr   = 64'h1000;
    exp_total = '0;
    if (bus.req_ready != '0) @(negedge clk);

    for (int k = 0; k < 11; k++) run_field(vecs[k]);

    // vu_done while idle must not move the pointer.
    pulse_done(4'd7);
    @(negedge clk);
    chk("stray_done_ptr", wr_ptr, exp_ptr);
    chk("stray_done_busy", 64'(busy), 64'd0);

`ifdef VARINT_SCHED_TIMEOUT_EN
    begin
      int cnt;
      post(1, 29'd1, 5'd4, 64'd1);
      wait_ready(1);
      cnt = 0;
      while (bus.vu_en && cnt < 200) begin
        cnt++;
        @(negedge clk);
      end
      chk("wd_tag_cycles", 64'(cnt), 64'(TOUT));
      chk("wd_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("wd_resp_err", 64'(bus.resp_err), 64'd1);
      chk("wd_resp_bytes", 64'(bus.resp_bytes), 64'd0);
      @(negedge clk);
      chk("wd_busy", 64'(busy), 64'd0);
      chk("wd_wr_ptr", wr_ptr, exp_ptr);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks);
    $fatal(1);
  end

endmodule
